ocx_dlx_rx_lane_sync_mon: RTL and testbench
===========================================

// Module: ocx_dlx_rx_lane_sync_mon
// PURPOSE
//  Per-lane sync-pattern monitor in the DLx receive path, directly upstream of the GTY/DLx reset shim.
//  Watches the gated per-lane receive blocks (8 lanes) for the training sync block.
//  Produces pb_io_o0_rx_run_lane[7:0]; the shim ANDs this to start its receiver retrain pulse.
//  Drops lanes back to hunt when rx init falls (transceiver retrained) or lane skew times out.
// PARAMETERS
//  SYNC_PATTERN   64'hFF00_FF00_FF00_FF00  payload of the sync block
//  SYNC_HDR       2'b10                    header that must accompany SYNC_PATTERN
//  SYNC_COUNT     8                        consecutive matching valid blocks for lane lock (1..255)
//  TIMEOUT_CYCLES 4096                     cycles allowed from first lane lock to all lanes locked (>=2)
// PORTS
//  opt_gckn               in   1    receive-domain clock; all logic on rising edge
//  dlx_reset              in   1    synchronous, active-high reset
//  ln_rx_valid            in   8    per-lane block valid (already gated by transceiver rx done)
//  ln_rx_header           in   16   lane n header = [2n+1:2n]
//  ln_rx_data             in   512  lane n payload = [64n+63:64n]
//  io_pb_o0_rx_init_done  in   8    rx init done from shim; only bit 0 is used (all bits identical)
//  pb_io_o0_rx_run_lane   out  8    lane n locked/running; registered
//  lane_locked            out  8    status: lane in LOCKED (waiting for init_done)
//  sync_timeout           out  1    one-cycle pulse when the skew timeout fires
// BEHAVIOUR
//  Reset: every lane FSM -> HUNT, match counters 0, timeout counter 0, all outputs 0.
//  match(n) = ln_rx_valid[n] & header==SYNC_HDR & data==SYNC_PATTERN; miss(n) = valid & ~match.
//  Cycles with ln_rx_valid[n]=0 hold lane n's state and counter unchanged.
//  Per-lane FSM (2-bit, registered):
//   HUNT   : match -> VERIFY, cnt=1 (if SYNC_COUNT==1 go straight to LOCKED); else stay, cnt=0.
//   VERIFY : match -> cnt+1; when cnt+1==SYNC_COUNT -> LOCKED; miss -> HUNT, cnt=0.
//   LOCKED : wait for init_done=1 -> RUN; block contents ignored (shim is resetting receiver).
//   RUN    : init_done=0 -> HUNT, cnt=0; block contents ignored.
//  pb_io_o0_rx_run_lane[n] = state in {LOCKED,RUN}; lane_locked[n] = state==LOCKED. Both decoded
//   from registered state: lock asserts the cycle after the SYNC_COUNT-th matching block is sampled.
//  Match counter width = $clog2(SYNC_COUNT+1); saturates, never wraps.
//  Skew timer (width $clog2(TIMEOUT_CYCLES+1)): counts while 0 < popcount(run_lane) < 8;
//   clears when run_lane==0 or 8'hFF. On reaching TIMEOUT_CYCLES: sync_timeout=1 next cycle,
//   all lanes forced to HUNT, counters and timer cleared.
//  Priority per lane, highest first: dlx_reset > timeout flush > init_done fall (RUN) > FSM step.
//  init_done rising while some lanes not yet locked: only LOCKED lanes move to RUN; others continue.
//  dlx_reset mid-VERIFY or mid-timeout: immediate return to reset state, no sync_timeout pulse.
// TESTING
//  1 All lanes send 8 valid sync blocks together -> run_lane 00->FF one cycle after 8th block; lane_locked=FF.
//  2 Lane 3 sends 5 sync, 1 bad header 2'b01, then 8 sync -> lane 3 locks only after the second run (14th block+1).
//  3 Lane 5 valid=0 for 10 cycles between sync blocks 4 and 5 -> counter holds at 4, lock after 8th valid match.
//  4 Lanes 0-6 lock, lane 7 never sees sync -> sync_timeout pulse after 4096 cycles, run_lane back to 00.
//  5 All locked, init_done 0->1 -> lane_locked FF->00, run_lane stays FF; init_done 1->0 -> run_lane 00 next cycle.
//  6 dlx_reset asserted for 1 cycle with lanes at cnt=6 -> all outputs 0, next lock needs a full 8 matches.

Source files
------------

// File: rtl/ocx_dlx_rx_lane_sync_mon_if.sv
// Receive-block and lane-status bundle between the DLx receive lanes and the sync monitor.
// The monitor sits on the slave side.
interface ocx_dlx_rx_lane_sync_mon_if;
   logic [7:0]   ln_rx_valid;
   logic [15:0]  ln_rx_header;
   logic [511:0] ln_rx_data;
   logic [7:0]   io_pb_o0_rx_init_done;
   logic [7:0]   pb_io_o0_rx_run_lane;
   logic [7:0]   lane_locked;
   logic         sync_timeout;

   modport master (
      output ln_rx_valid,
      output ln_rx_header,
      output ln_rx_data,
      output io_pb_o0_rx_init_done,
      input  pb_io_o0_rx_run_lane,
      input  lane_locked,
      input  sync_timeout
   );

   modport slave (
      input  ln_rx_valid,
      input  ln_rx_header,
      input  ln_rx_data,
      input  io_pb_o0_rx_init_done,
      output pb_io_o0_rx_run_lane,
      output lane_locked,
      output sync_timeout
   );
endinterface

// File: rtl/ocx_dlx_rx_lane_sync_mon.sv
// Per-lane sync-block hunter for the 8-lane DLx receive path. It drives run_lane into the
// GTY/DLx reset shim and flushes every lane back to hunt when lane-to-lane skew times out.
module ocx_dlx_rx_lane_sync_mon #(
   parameter logic [63:0] SYNC_PATTERN   = 64'hFF00_FF00_FF00_FF00,
   parameter logic [1:0]  SYNC_HDR       = 2'b10,
   parameter int          SYNC_COUNT     = 8,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input logic                          opt_gckn,
   input logic                          dlx_reset,
   ocx_dlx_rx_lane_sync_mon_if.slave    bus
);

   localparam int LANES = 8;
   localparam int CW    = $clog2(SYNC_COUNT + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LOCK = CW'(SYNC_COUNT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [TW-1:0] TMR_FIRE = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2,
      RUN    = 2'd3
   } lane_state_e;

   lane_state_e   state_q [LANES];
   lane_state_e   state_d [LANES];
   logic [CW-1:0] cnt_q   [LANES];
   logic [CW-1:0] cnt_d   [LANES];
   logic [TW-1:0] tmr_q, tmr_d;
   logic          timeout_q, timeout_d;

   logic [LANES-1:0] match, miss, run_lane, locked;
   logic             init_done, fire, partial;
   logic             unused_init_done;

   // All init_done bits carry the same value; only bit 0 is observed.
   assign init_done        = bus.io_pb_o0_rx_init_done[0];
   assign unused_init_done = ^bus.io_pb_o0_rx_init_done[7:1];

   always_comb begin
      for (int n = 0; n < LANES; n++) begin
         match[n] = bus.ln_rx_valid[n]
                    && (bus.ln_rx_header[2*n +: 2] == SYNC_HDR)
                    && (bus.ln_rx_data[64*n +: 64] == SYNC_PATTERN);
         miss[n]  = bus.ln_rx_valid[n] && !match[n];
      end
   end

   always_comb begin
      for (int n = 0; n < LANES; n++) begin
         run_lane[n] = (state_q[n] == LOCKED) || (state_q[n] == RUN);
         locked[n]   = (state_q[n] == LOCKED);
      end
   end

   // Skew window is open while some, but not all, lanes are running.
   assign partial = (run_lane != '0) && (run_lane != '1);
   assign fire    = (tmr_q == TMR_FIRE);

   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      tmr_d     = '0;
      timeout_d = fire;
      if (!fire && partial) begin
         tmr_d = tmr_q + TMR_ONE;
      end

      for (int n = 0; n < LANES; n++) begin
         state_d[n] = state_q[n];
         cnt_d[n]   = cnt_q[n];

         if (fire) begin
            state_d[n] = HUNT;
            cnt_d[n]   = '0;
         end else if ((state_q[n] == RUN) && !init_done) begin
            state_d[n] = HUNT;
            cnt_d[n]   = '0;
         end else begin
            unique case (state_q[n])
               HUNT: begin
                  if (match[n]) begin
                     cnt_d[n]   = CNT_ONE;
                     state_d[n] = (SYNC_COUNT == 1) ? LOCKED : VERIFY;
                  end else begin
                     cnt_d[n] = '0;
                  end
               end
               VERIFY: begin
                  if (match[n]) begin
                     if (cnt_q[n] != CNT_LOCK) begin
                        cnt_d[n] = cnt_q[n] + CNT_ONE;
                     end
                     if ((cnt_q[n] + CNT_ONE) == CNT_LOCK) begin
                        state_d[n] = LOCKED;
                     end
                  end else if (miss[n]) begin
                     state_d[n] = HUNT;
                     cnt_d[n]   = '0;
                  end
               end
               // Block contents are meaningless here: the shim is resetting the receiver.
               LOCKED: begin
                  if (init_done) begin
                     state_d[n] = RUN;
                  end
               end
               RUN: begin
                  state_d[n] = RUN;
               end
               default: begin
                  state_d[n] = HUNT;
                  cnt_d[n]   = '0;
               end
            endcase
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every lane samples the same pre-edge values.
   always_ff @(posedge opt_gckn) begin
      if (dlx_reset) begin
         for (int n = 0; n < LANES; n++) begin
            state_q[n] <= HUNT;
            cnt_q[n]   <= '0;
         end
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         for (int n = 0; n < LANES; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
         end
         tmr_q     <= tmr_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.pb_io_o0_rx_run_lane = run_lane;
   assign bus.lane_locked          = locked;
   assign bus.sync_timeout         = timeout_q;

endmodule

// File: tb/tb_ocx_dlx_rx_lane_sync_mon.sv
// Scoreboarded bench for the DLx receive lane sync monitor: lock, retry, hold, init handshake,
// reset during verify, skew timeout, and reset during the skew window.
module tb_ocx_dlx_rx_lane_sync_mon;

   localparam logic [63:0] SYNC    = 64'hFF00_FF00_FF00_FF00;
   localparam logic [1:0]  HDR     = 2'b10;
   localparam int          TIMEOUT = 4096;

   logic opt_gckn  = 1'b0;
   logic dlx_reset = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   logic [16:0] exp_q [$];
   string       tag_q [$];

   ocx_dlx_rx_lane_sync_mon_if bus();

   ocx_dlx_rx_lane_sync_mon dut (
      .opt_gckn  (opt_gckn),
      .dlx_reset (dlx_reset),
      .bus       (bus)
   );

   always #5 opt_gckn = ~opt_gckn;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=done");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Bad header lanes carry 2'b01; bad data lanes carry the inverted pattern.
   task automatic drive(input logic [7:0] v, input logic [7:0] good_hdr,
                        input logic [7:0] good_data, input logic init);
      for (int n = 0; n < 8; n++) begin
         bus.ln_rx_valid[n]           = v[n];
         bus.ln_rx_header[2*n +: 2]   = good_hdr[n] ? HDR : 2'b01;
         bus.ln_rx_data[64*n +: 64]   = good_data[n] ? SYNC : ~SYNC;
      end
      bus.io_pb_o0_rx_init_done = {8{init}};
   endtask

   task automatic step(input string tag, input logic [7:0] v, input logic [7:0] good_hdr,
                       input logic [7:0] good_data, input logic init,
                       input logic [7:0] exp_run, input logic [7:0] exp_locked, input logic exp_to);
      logic [16:0] e;
      string       t;
      drive(v, good_hdr, good_data, init);
      exp_q.push_back({exp_run, exp_locked, exp_to});
      tag_q.push_back(tag);
      @(posedge opt_gckn);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_run"},     {24'd0, bus.pb_io_o0_rx_run_lane}, {24'd0, e[16:9]});
      check({t, "_locked"},  {24'd0, bus.lane_locked},          {24'd0, e[8:1]});
      check({t, "_timeout"}, {31'd0, bus.sync_timeout},         {31'd0, e[0]});
   endtask

   task automatic idle_wait_timeout(input string tag, input logic [7:0] hold_run,
                                    input bit expect_pulse);
      int n    = 0;
      bit got  = 0;
      bit held = 1;
      drive(8'h00, 8'hFF, 8'hFF, 1'b0);
      while (n < TIMEOUT + 20 && !got) begin
         @(posedge opt_gckn);
         #1;
         n++;
         if (bus.sync_timeout) got = 1;
         else if (bus.pb_io_o0_rx_run_lane !== hold_run) held = 0;
      end
      check({tag, "_pulse_seen"}, {31'd0, got}, {31'd0, expect_pulse});
      check({tag, "_run_held"}, {31'd0, held}, 32'd1);
      if (expect_pulse) begin
         check({tag, "_latency_in_window"}, {31'd0, (n >= TIMEOUT && n <= TIMEOUT + 2)}, 32'd1);
         check({tag, "_flush_run"}, {24'd0, bus.pb_io_o0_rx_run_lane}, 32'd0);
         check({tag, "_flush_locked"}, {24'd0, bus.lane_locked}, 32'd0);
         @(posedge opt_gckn);
         #1;
         check({tag, "_pulse_one_cycle"}, {31'd0, bus.sync_timeout}, 32'd0);
      end
   endtask

   initial begin
      drive(8'h00, 8'hFF, 8'hFF, 1'b0);
      repeat (2) @(posedge opt_gckn);
      #1;
      check("reset_run",     {24'd0, bus.pb_io_o0_rx_run_lane}, 32'd0);
      check("reset_locked",  {24'd0, bus.lane_locked},          32'd0);
      check("reset_timeout", {31'd0, bus.sync_timeout},         32'd0);
      dlx_reset = 1'b0;

      // All lanes lock together on the 8th block.
      for (int i = 0; i < 8; i++)
         step("t1_sync", 8'hFF, 8'hFF, 8'hFF, 1'b0,
              (i == 7) ? 8'hFF : 8'h00, (i == 7) ? 8'hFF : 8'h00, 1'b0);

      // init_done handshake: LOCKED -> RUN, then fall back to HUNT.
      step("t5_init_rise", 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h00, 1'b0);
      step("t5_run_hold",  8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h00, 1'b0);
      step("t5_init_fall", 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
      step("t5_idle",      8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);

      // Lane 3: 5 sync, one bad header, then 8 sync.
      for (int i = 0; i < 14; i++)
         step("t2_lane3", 8'h08, (i == 5) ? 8'hF7 : 8'hFF, 8'hFF, 1'b0,
              (i == 13) ? 8'h08 : 8'h00, (i == 13) ? 8'h08 : 8'h00, 1'b0);
      step("t2_init_rise", 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h08, 8'h00, 1'b0);
      step("t2_init_fall", 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);

      // Lane 5: 4 sync, 10 invalid cycles, 4 more sync.
      for (int i = 0; i < 18; i++)
         step("t3_lane5", (i >= 4 && i < 14) ? 8'h00 : 8'h20, 8'hFF, 8'hFF, 1'b0,
              (i == 17) ? 8'h20 : 8'h00, (i == 17) ? 8'h20 : 8'h00, 1'b0);
      step("t3_init_rise", 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h20, 8'h00, 1'b0);
      step("t3_init_fall", 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);

      // Reset at cnt=6 forces a full 8 matches afterwards.
      for (int i = 0; i < 6; i++)
         step("t6_pre", 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
      dlx_reset = 1'b1;
      step("t6_reset", 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
      dlx_reset = 1'b0;
      for (int i = 0; i < 8; i++)
         step("t6_relock", 8'hFF, 8'hFF, 8'hFF, 1'b0,
              (i == 7) ? 8'hFF : 8'h00, (i == 7) ? 8'hFF : 8'h00, 1'b0);
      step("t6_init_rise", 8'h00, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h00, 1'b0);
      step("t6_init_fall", 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);

      // Lanes 0-6 lock, lane 7 only ever sees corrupted payload -> skew timeout.
      for (int i = 0; i < 8; i++)
         step("t4_lock", 8'hFF, 8'hFF, 8'h7F, 1'b0,
              (i == 7) ? 8'h7F : 8'h00, (i == 7) ? 8'h7F : 8'h00, 1'b0);
      idle_wait_timeout("t4", 8'h7F, 1'b1);

      // Reset inside the skew window: no pulse may follow.
      for (int i = 0; i < 8; i++)
         step("t7_lock", 8'h01, 8'hFF, 8'hFF, 1'b0,
              (i == 7) ? 8'h01 : 8'h00, (i == 7) ? 8'h01 : 8'h00, 1'b0);
      drive(8'h00, 8'hFF, 8'hFF, 1'b0);
      repeat (50) @(posedge opt_gckn);
      dlx_reset = 1'b1;
      step("t7_reset", 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
      dlx_reset = 1'b0;
      idle_wait_timeout("t7", 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
